burst_read_prefetch: RTL

Frame prefetcher that sits directly downstream of the Avalon-MM burst read master and also drives its control port. It walks a frame buffer in SDRAM as a sequence of fixed-length bursts and collects the returned beats in an internal FIFO. It presents the data to the video/processing pipeline as a valid/ready stream. A new burst is issued only when the FIFO has guaranteed room for the whole burst, so returning read data never needs back-pressure.

---
 rtl/burst_read_prefetch_pkg.sv | 12 +
 rtl/burst_read_prefetch_fifo.sv | 44 ++++
 rtl/burst_read_prefetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/burst_read_prefetch_pkg.sv
// Shared types for the burst read prefetcher: one-hot FSM state encoding.
package burst_read_prefetch_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ISSUE = 5'b00010,
        ST_ACK   = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_DRAIN = 5'b10000
    } state_t;

endpackage

// File: rtl/burst_read_prefetch_fifo.sv
// Show-ahead register FIFO with wrap-bit pointers; the caller never pushes into a
// full FIFO without a same-cycle pop, and never pops an empty one.
module prefetch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_AW    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_AW:0]      count
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW:0]      wr_ptr;
    logic [FIFO_AW:0]      rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
    end

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // Gate the head word so the stream data reads zero whenever nothing is valid.
    assign rd_data = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: rtl/burst_read_prefetch.sv
// Frame prefetcher: issues fixed-length bursts to an Avalon-MM burst read master only
// when the FIFO has room reserved for every beat, then streams the beats out.
module burst_read_prefetch
    import burst_read_prefetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTES_PER_WORD = 4,
    parameter int BURST_WIDTH    = 4,
    parameter int BURST_LEN      = 8,
    parameter int LENGTH_WIDTH   = 24,
    parameter int FIFO_DEPTH     = 32,
    parameter int FIFO_AW        = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_go,
    input  logic [ADDRESS_WIDTH-1:0] cfg_base,
    input  logic [LENGTH_WIDTH-1:0]  cfg_words,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rd_start,
    output logic [ADDRESS_WIDTH-1:0] rd_baseaddress,
    output logic [BURST_WIDTH-1:0]   rd_burstcount,
    input  logic                     rd_busy,
    input  logic                     rd_datavalid,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_sof,
    input  logic                     out_ready
);
    localparam logic [FIFO_AW:0] RES_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0] RES_BURST = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] RES_LIMIT = (FIFO_AW+1)'(FIFO_DEPTH - BURST_LEN);
    localparam logic [FIFO_AW:0] FIFO_CAP  = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(BURST_LEN * BYTES_PER_WORD);

    state_t                    state;
    state_t                    state_next;
    logic [ADDRESS_WIDTH-1:0]  addr;
    logic [LENGTH_WIDTH-1:0]   bursts_left;
    logic [FIFO_AW:0]          reserved;
    logic                      sof_pending;
    logic                      go_accept;
    logic                      issue;
    logic                      drain_exit;
    logic                      push;
    logic                      pop;
    logic                      overflow;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FIFO_AW:0]          fifo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (go_accept) state_next = ST_ISSUE;
            ST_ISSUE: begin
                if (bursts_left == '0) state_next = ST_DRAIN;
                else if (issue)        state_next = ST_ACK;
            end
            ST_ACK:   if (rd_busy)    state_next = ST_WAIT;
            ST_WAIT:  if (!rd_busy)   state_next = ST_ISSUE;
            ST_DRAIN: if (drain_exit) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        go_accept  = 1'b0;
        issue      = 1'b0;
        drain_exit = 1'b0;
        case (state)
            ST_IDLE:  go_accept  = cfg_go;
            ST_ISSUE: issue      = (bursts_left != '0) && !rd_busy && (reserved <= RES_LIMIT);
            ST_DRAIN: drain_exit = (reserved == '0);
            default:  ;
        endcase
    end

    // Stream handshake: a beat transfers on every cycle with out_valid and out_ready both
    // high; out_valid never drops and out_data/out_sof never change until that transfer.
    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign out_sof   = out_valid && sof_pending;
    assign done      = pop && (reserved == RES_ONE) && (bursts_left == '0);
    assign push      = rd_datavalid && ((fifo_count != FIFO_CAP) || pop);
    assign overflow  = rd_datavalid && fifo_full && !pop;
    assign rd_burstcount = BURST_WIDTH'(BURST_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr           <= '0;
            bursts_left    <= '0;
            reserved       <= '0;
            busy           <= 1'b0;
            sof_pending    <= 1'b0;
            err            <= 1'b0;
            rd_start       <= 1'b0;
            rd_baseaddress <= '0;
        end else begin
            rd_start <= issue;
            if (go_accept) begin
                addr        <= cfg_base;
                bursts_left <= LENGTH_WIDTH'(cfg_words / BURST_LEN);
                busy        <= 1'b1;
            end
            if (issue) begin
                rd_baseaddress <= addr;
                addr           <= addr + ADDR_STEP;
                bursts_left    <= bursts_left - LENGTH_WIDTH'(1);
            end
            if (drain_exit) busy <= 1'b0;
            if (go_accept)  sof_pending <= 1'b1;
            else if (pop)   sof_pending <= 1'b0;
            // Reservation covers FIFO contents plus beats still owed by the master.
            reserved <= reserved + (issue ? RES_BURST : '0) - (pop ? RES_ONE : '0);
            if (overflow) err <= 1'b1;
        end
    end

    prefetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (rd_data),
        .pop     (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
